// File: rtl/boundary_padder.sv
// boundary_padder: wraps a WIDTH x HEIGHT raster frame with a border of
// B=(KERNEL_SIZE-1)/2 pixels on every side, emitting (WIDTH+2B)x(HEIGHT+2B)
// pixels through a registered valid/ready output stage.
// Optional feature macro PAD_REPLICATE_EN: pad pixels replicate the nearest
// active pixel via a single-row buffer; undefined -> pad pixels = PAD_VALUE.
module boundary_padder #(
  parameter int unsigned       WIDTH       = 320,
  parameter int unsigned       HEIGHT      = 240,
  parameter int unsigned       KERNEL_SIZE = 3,
  parameter int unsigned       DATA_W      = 24,
  parameter logic [DATA_W-1:0] PAD_VALUE   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              newFrame,
  input  logic              iValid,
  output logic              iReady,
  input  logic [DATA_W-1:0] iData,
  output logic              oValid,
  input  logic              oReady,
  output logic [DATA_W-1:0] oData,
  output logic              oEol,
  output logic              oDone
);

  localparam int unsigned B  = (KERNEL_SIZE - 1) / 2;
  localparam int unsigned PW = WIDTH + 2 * B;
  localparam int unsigned PH = HEIGHT + 2 * B;
  localparam int unsigned XW = $clog2(PW);
  localparam int unsigned YW = $clog2(PH);

  localparam logic [2:0] IDLE   = 3'd0;
`ifdef PAD_REPLICATE_EN
  localparam logic [2:0] FILL   = 3'd1;
`endif
  localparam logic [2:0] TOP    = 3'd2;
  localparam logic [2:0] ROW    = 3'd3;
  localparam logic [2:0] BOTTOM = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]        state;
  logic [XW-1:0]     px;
  logic [YW-1:0]     py;
  logic              finalLoaded;
  logic              regFree;
  logic              running;
  logic              pxGeLeft;
  logic              pxLtRight;
  logic              interior;
  logic              pxLast;
  logic              pyLast;
  logic [YW-1:0]     pyNext;
  logic              consume;
  logic              waitValid;
  logic              load;
  logic [DATA_W-1:0] loadPix;

  assign regFree   = !oValid || oReady;
  assign running   = ((state == TOP) || (state == ROW) || (state == BOTTOM)) && !finalLoaded;
  assign pxGeLeft  = (px >= XW'(B));
  assign pxLtRight = (px < XW'(WIDTH + B));
  assign interior  = (state == ROW) && pxGeLeft && pxLtRight;
  assign pxLast    = (px == XW'(PW - 1));
  assign pyLast    = (py == YW'(PH - 1));
  assign pyNext    = py + YW'(1);
  assign oDone     = (state == DONE);

`ifdef PAD_REPLICATE_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [DATA_W-1:0] rowBuf [WIDTH];
  logic [CW-1:0]     col;
  logic              row0;
  logic              leftPeek;

  assign row0 = (py == YW'(B));

  // Buffer column: fill counter during FILL, otherwise px clamped to the active area
  always_comb begin
    if (state == FILL)   col = CW'(px);
    else if (!pxGeLeft)  col = '0;
    else if (!pxLtRight) col = CW'(WIDTH - 1);
    else                 col = CW'(px - XW'(B));
  end

  // Row 0 is replayed from the buffer; left pad of later rows peeks at the
  // not-yet-consumed column-0 input since the buffer still holds the row above.
  always_comb begin
    consume   = running && interior && !row0;
    leftPeek  = running && (state == ROW) && !row0 && !pxGeLeft;
    waitValid = consume || leftPeek;
    loadPix   = (consume || leftPeek) ? iData : rowBuf[col];
    load      = running && regFree && (!waitValid || iValid);
    iReady    = (consume && regFree) || (state == FILL);
  end

  // Each accepted pixel overwrites its column so the buffer trails the input by one row
  always_ff @(posedge clk) begin
    if (iValid && iReady) rowBuf[col] <= iData;
  end
`else
  // Interior positions take input; pad positions load the constant without consuming
  always_comb begin
    consume   = running && interior;
    waitValid = consume;
    loadPix   = consume ? iData : PAD_VALUE;
    load      = running && regFree && (!waitValid || iValid);
    iReady    = consume && regFree;
  end
`endif

  // Output register: load a new pixel when free, otherwise hold until accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oValid <= 1'b0;
      oData  <= '0;
      oEol   <= 1'b0;
    end else if (load) begin
      oValid <= 1'b1;
      oData  <= loadPix;
      oEol   <= pxLast;
    end else if (oReady) begin
      oValid <= 1'b0;
    end
  end

  // Frame sequencing and padded-coordinate tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      px          <= '0;
      py          <= '0;
      finalLoaded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (newFrame) begin
`ifdef PAD_REPLICATE_EN
            state <= FILL;
`else
            state <= TOP;
`endif
            px          <= '0;
            py          <= '0;
            finalLoaded <= 1'b0;
          end
        end
`ifdef PAD_REPLICATE_EN
        FILL: begin
          if (iValid) begin
            if (px == XW'(WIDTH - 1)) begin
              px    <= '0;
              state <= TOP;
            end else begin
              px <= px + XW'(1);
            end
          end
        end
`endif
        TOP, ROW, BOTTOM: begin
          if (load) begin
            if (pxLast) begin
              px <= '0;
              if (pyLast) begin
                py          <= '0;
                finalLoaded <= 1'b1;
              end else begin
                py <= pyNext;
                if (pyNext == YW'(B))          state <= ROW;
                if (pyNext == YW'(HEIGHT + B)) state <= BOTTOM;
              end
            end else begin
              px <= px + XW'(1);
            end
          end else if (finalLoaded && oValid && oReady) begin
            finalLoaded <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boundary_padder.sv
// Directed bench for boundary_padder: two instances (K=3 and K=5, both 4x3),
// shared input stimulus, outputs selected by 'sel'.
module tb_boundary_padder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        newFrameA = 1'b0, newFrameB = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady = 1'b0;
  logic [23:0] iData = '0;
  logic        sel = 1'b0;

  logic        iReadyA, oValidA, oEolA, oDoneA;
  logic        iReadyB, oValidB, oEolB, oDoneB;
  logic [23:0] oDataA, oDataB;

  logic        iReadyS, oValidS, oEolS, oDoneS;
  logic [23:0] oDataS;

  int checks = 0;
  int errors = 0;
  logic [23:0] cap [0:63];

  always #5 clk = ~clk;

  boundary_padder #(.WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(3), .DATA_W(24), .PAD_VALUE(24'h0)) dutA (
    .clk(clk), .reset(reset), .newFrame(newFrameA), .iValid(iValid), .iReady(iReadyA),
    .iData(iData), .oValid(oValidA), .oReady(oReady), .oData(oDataA), .oEol(oEolA), .oDone(oDoneA)
  );

  boundary_padder #(.WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(5), .DATA_W(24), .PAD_VALUE(24'h0)) dutB (
    .clk(clk), .reset(reset), .newFrame(newFrameB), .iValid(iValid), .iReady(iReadyB),
    .iData(iData), .oValid(oValidB), .oReady(oReady), .oData(oDataB), .oEol(oEolB), .oDone(oDoneB)
  );

  assign iReadyS = sel ? iReadyB : iReadyA;
  assign oValidS = sel ? oValidB : oValidA;
  assign oEolS   = sel ? oEolB   : oEolA;
  assign oDoneS  = sel ? oDoneB  : oDoneA;
  assign oDataS  = sel ? oDataB  : oDataA;

  // Expected padded pixel for inputs 1..12 delivered in raster order (4x3 frame)
  function automatic logic [23:0] exp_pix(input int px, input int py, input int b);
    int cx, cy;
    cx = px - b;
    cy = py - b;
`ifdef PAD_REPLICATE_EN
    if (cx < 0) cx = 0;
    if (cx > 3) cx = 3;
    if (cy < 0) cy = 0;
    if (cy > 2) cy = 2;
    return 24'(cy * 4 + cx + 1);
`else
    if (cx < 0 || cx > 3 || cy < 0 || cy > 2) return 24'h0;
    return 24'(cy * 4 + cx + 1);
`endif
  endfunction

  // Runs one frame on the selected instance. resetBeat>=0 asserts reset right
  // after that beat; nfBeat>=0 re-pulses newFrame while that many beats are done.
  task automatic run_frame(input bit useB, input bit toggle, input int resetBeat, input int nfBeat);
    int b, pw, ph, total;
    int beats, nextIn, cyc, lastBeatCyc, doneCyc;
    int px, py;
    bit stallPrev, inAcc;
    logic [23:0] held, expv;
    b = useB ? 2 : 1;
    pw = 4 + 2 * b;
    ph = 3 + 2 * b;
    total = pw * ph;
    beats = 0; nextIn = 1; cyc = 0; lastBeatCyc = -10; doneCyc = -1;
    stallPrev = 0; held = '0;
    sel = useB;
    @(negedge clk);
    iValid = 1'b0;
    oReady = 1'b1;
    if (useB) newFrameB = 1'b1; else newFrameA = 1'b1;
    @(negedge clk);
    newFrameA = 1'b0;
    newFrameB = 1'b0;
    while (cyc < 600 && doneCyc < 0) begin
      oReady = toggle ? (cyc % 2 == 0) : 1'b1;
      iValid = (nextIn <= 12);
      iData  = 24'(nextIn);
      if (nfBeat >= 0) begin
        if (useB) newFrameB = (beats == nfBeat); else newFrameA = (beats == nfBeat);
      end
      #1;
      if (stallPrev) begin
        checks++;
        if (oValidS !== 1'b1 || oDataS !== held) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d oValid=%b oData=%0d expected oValid=1 oData=%0d", cyc, oValidS, oDataS, held);
        end
      end
      if (oDoneS === 1'b1) doneCyc = cyc;
      if (oValidS && oReady) begin
        px = beats % pw;
        py = beats / pw;
        expv = exp_pix(px, py, b);
        if (beats < 64) cap[beats] = oDataS;
        checks++;
        if (oDataS !== expv) begin
          errors++;
          $display("FAIL beat_data beat=%0d got %0d expected %0d", beats + 1, oDataS, expv);
        end
        checks++;
        if (oEolS !== (px == pw - 1)) begin
          errors++;
          $display("FAIL beat_eol beat=%0d got %b expected %b", beats + 1, oEolS, (px == pw - 1));
        end
        beats++;
        lastBeatCyc = cyc;
        if (resetBeat >= 0 && beats == resetBeat) begin
          reset = 1'b0;
          #1;
          checks++;
          if ({oValidS, oDataS, oEolS, oDoneS, iReadyS} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset got oValid=%b oData=%0d oEol=%b oDone=%b iReady=%b expected all 0",
                     oValidS, oDataS, oEolS, oDoneS, iReadyS);
          end
          @(negedge clk);
          @(negedge clk);
          reset = 1'b1;
          iValid = 1'b1;
          oReady = 1'b1;
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (oValidS !== 1'b0 || iReadyS !== 1'b0) begin
              errors++;
              $display("FAIL post_reset_idle cyc=%0d oValid=%b iReady=%b expected 0 0", k, oValidS, iReadyS);
            end
          end
          iValid = 1'b0;
          newFrameA = 1'b0;
          newFrameB = 1'b0;
          return;
        end
      end
      stallPrev = oValidS && !oReady;
      held = oDataS;
      inAcc = iValid && iReadyS;
      @(negedge clk);
      if (inAcc) nextIn++;
      cyc++;
    end
    newFrameA = 1'b0;
    newFrameB = 1'b0;
    iValid = 1'b0;
    checks++;
    if (doneCyc < 0) begin
      errors++;
      $display("FAIL done_timeout got no oDone within 600 cycles expected oDone");
    end
    checks++;
    if (beats != total) begin
      errors++;
      $display("FAIL beat_count got %0d expected %0d", beats, total);
    end
    checks++;
    if (nextIn != 13) begin
      errors++;
      $display("FAIL inputs_consumed got %0d expected 12", nextIn - 1);
    end
    checks++;
    if (doneCyc != lastBeatCyc + 1) begin
      errors++;
      $display("FAIL done_latency got cycle %0d expected %0d", doneCyc, lastBeatCyc + 1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (oDoneS !== 1'b0 || oValidS !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got oDone=%b oValid=%b expected 0 0", oDoneS, oValidS);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({oValidA, oDataA, oEolA, oDoneA, iReadyA, oValidB, oDoneB, iReadyB} !== 31'h0) begin
      errors++;
      $display("FAIL reset_state got oValid=%b oData=%0d oEol=%b oDone=%b iReady=%b expected all 0",
               oValidA, oDataA, oEolA, oDoneA, iReadyA);
    end
    @(negedge clk);
    reset = 1'b1;
    iValid = 1'b1;
    oReady = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (oValidA !== 1'b0 || iReadyA !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_output got oValid=%b iReady=%b expected 0 0", oValidA, iReadyA);
    end
    iValid = 1'b0;
  endtask

  task automatic test_basic();
    logic [23:0] got;
    run_frame(1'b0, 1'b0, -1, -1);
`ifdef PAD_REPLICATE_EN
    got = cap[0];  checks++; if (got !== 24'd1)  begin errors++; $display("FAIL rep_beat1 got %0d expected 1", got); end
    got = cap[5];  checks++; if (got !== 24'd4)  begin errors++; $display("FAIL rep_beat6 got %0d expected 4", got); end
    got = cap[24]; checks++; if (got !== 24'd9)  begin errors++; $display("FAIL rep_beat25 got %0d expected 9", got); end
    got = cap[29]; checks++; if (got !== 24'd12) begin errors++; $display("FAIL rep_beat30 got %0d expected 12", got); end
`else
    got = cap[0];  checks++; if (got !== 24'd0)  begin errors++; $display("FAIL pad_beat1 got %0d expected 0", got); end
    got = cap[7];  checks++; if (got !== 24'd1)  begin errors++; $display("FAIL first_interior got %0d expected 1", got); end
    got = cap[22]; checks++; if (got !== 24'd12) begin errors++; $display("FAIL last_interior got %0d expected 12", got); end
    got = cap[29]; checks++; if (got !== 24'd0)  begin errors++; $display("FAIL pad_beat30 got %0d expected 0", got); end
`endif
  endtask

  task automatic test_stall();
    run_frame(1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_kernel5();
    run_frame(1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_midframe_reset();
    run_frame(1'b0, 1'b0, 10, -1);
  endtask

  task automatic test_newframe_ignored();
    run_frame(1'b0, 1'b0, -1, 15);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_kernel5();
    test_midframe_reset();
    test_basic();
    test_newframe_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
